// File: rtl/cpu_fpu_pkg.sv
// Shared FPU definitions: binary32 field layout, internal exponent type,
// canonical NaN and the unpack helper used by the divider and multiply-add units.
package cpu_fpu_pkg;

  localparam int unsigned FP_W   = 32;  // binary32 word
  localparam int unsigned EXP_W  = 10;  // internal signed, unbiased exponent
  localparam int unsigned MANT_W = 24;  // mantissa including hidden bit

  typedef logic signed [EXP_W-1:0] exp_t;
  typedef logic [MANT_W-1:0]       mant_t;

  localparam exp_t EXP_BIAS = 10'sd127;
  localparam exp_t EXP_MIN  = -10'sd126;  // smallest normal exponent
  localparam exp_t EXP_INF  = 10'sd128;   // biased field 0xFF
  localparam exp_t EXP_DEN  = -10'sd127;  // biased field 0x00

  localparam logic [FP_W-1:0] CANON_NAN = 32'hFFC0_0000;

  // Packed binary32 word
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // Unpacked operand: unbiased exponent, fraction with hidden bit still clear
  typedef struct packed {
    logic  sign;
    exp_t  exp;
    mant_t mant;
  } unpacked_t;

  function automatic unpacked_t fp_unpack(input fp32_t x);
    unpacked_t u;
    u.sign = x.sign;
    u.exp  = exp_t'({2'b00, x.exp}) - EXP_BIAS;
    u.mant = {1'b0, x.frac};
    return u;
  endfunction

endpackage

// File: rtl/cpu_fpu_round_pack.sv
// Round-to-nearest-even and binary32 packing (combinational).
// Ports:
//   z_s            result sign
//   z_e            unbiased exponent, already >= -126
//   z_m            24-bit mantissa before rounding
//   guard/round/sticky  bits below the mantissa LSB
//   result         packed binary32 (signed inf on overflow, denormal field when small)
module cpu_fpu_round_pack
  import cpu_fpu_pkg::*;
(
  input  logic                    z_s,
  input  logic signed [EXP_W-1:0] z_e,
  input  logic [MANT_W-1:0]       z_m,
  input  logic                    guard,
  input  logic                    round,
  input  logic                    sticky,
  output logic [FP_W-1:0]         result
);

  logic                    round_up;
  logic [MANT_W-1:0]       m_r;
  logic signed [EXP_W-1:0] e_r;
  fp32_t                   pk;

  always_comb begin
    round_up = guard & (round | sticky | z_m[0]);
    m_r      = z_m + MANT_W'(round_up);
    e_r      = z_e;
    // all-ones mantissa wraps to zero; carry moves into the exponent
    if (round_up && (z_m == '1)) e_r = z_e + 10'sd1;

    pk.sign = z_s;
    pk.exp  = 8'(e_r + EXP_BIAS);
    pk.frac = m_r[22:0];
    if ((e_r == EXP_MIN) && !m_r[MANT_W-1]) pk.exp = '0;
    if (e_r > EXP_BIAS) begin
      pk.exp  = '1;
      pk.frac = '0;
    end
  end

  assign result = pk;

endmodule

// File: rtl/cpu_fpu_div.sv
// Iterative binary32 divider (op1 / op2): special-case screen, operand
// normalisation, 28-step restoring quotient loop, underflow shift, RNE rounding.
// Ports:
//   i_clock    clock, rising edge
//   i_reset    synchronous active-high reset
//   i_request  held high from operand presentation until o_ready is seen
//   i_op1      dividend, captured in IDLE
//   i_op2      divisor, captured in IDLE
//   o_ready    result valid, held while i_request stays high
//   o_result   quotient, held until the next PUT_Z
module cpu_fpu_div
  import cpu_fpu_pkg::*;
(
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_request,
  input  logic [FP_W-1:0] i_op1,
  input  logic [FP_W-1:0] i_op2,
  output logic            o_ready,
  output logic [FP_W-1:0] o_result
);

  localparam int unsigned Q_W   = 28;
  localparam int unsigned REM_W = 25;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    SPECIAL = 4'd1,
    NORM_A  = 4'd2,
    NORM_B  = 4'd3,
    DIVIDE  = 4'd4,
    POST    = 4'd5,
    NORM_2  = 4'd6,
    ROUND   = 4'd7,
    PACK    = 4'd8,
    PUT_Z   = 4'd9
  } state_t;

  state_t state, state_nxt;

  unpacked_t ua, ub;
  mant_t     a_m, b_m, z_m;
  exp_t      a_e, b_e, z_e;
  logic      z_s;
  logic [Q_W-1:0]   q;
  logic [REM_W-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             guard, round_bit, sticky;
  logic [FP_W-1:0]  z;
  logic [FP_W-1:0]  rp_result;

  logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic            special_hit;
  logic [FP_W-1:0] special_z;
  logic            ready_nxt, result_load;

  assign ua = fp_unpack(i_op1);
  assign ub = fp_unpack(i_op2);

  // Operand classification on the captured (hidden-bit-clear) fields
  assign a_nan  = (a_e == EXP_INF) && (a_m != '0);
  assign b_nan  = (b_e == EXP_INF) && (b_m != '0);
  assign a_inf  = (a_e == EXP_INF) && (a_m == '0);
  assign b_inf  = (b_e == EXP_INF) && (b_m == '0);
  assign a_zero = (a_e == EXP_DEN) && (a_m == '0);
  assign b_zero = (b_e == EXP_DEN) && (b_m == '0);

  // Special-case result, first match wins
  always_comb begin
    special_hit = 1'b1;
    special_z   = CANON_NAN;
    if (a_nan || b_nan)          special_z = CANON_NAN;
    else if (a_inf && b_inf)     special_z = CANON_NAN;
    else if (a_zero && b_zero)   special_z = CANON_NAN;
    else if (a_inf)              special_z = {z_s, 8'hFF, 23'd0};
    else if (b_inf)              special_z = {z_s, 31'd0};
    else if (b_zero)             special_z = {z_s, 8'hFF, 23'd0};
    else if (a_zero)             special_z = {z_s, 31'd0};
    else                         special_hit = 1'b0;
  end

  cpu_fpu_round_pack u_round_pack (
    .z_s    (z_s),
    .z_e    (z_e),
    .z_m    (z_m),
    .guard  (guard),
    .round  (round_bit),
    .sticky (sticky),
    .result (rp_result)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_request) state_nxt = SPECIAL;
      SPECIAL: state_nxt = special_hit ? PUT_Z : NORM_A;
      NORM_A:  if (a_m[MANT_W-1]) state_nxt = NORM_B;
      NORM_B:  if (b_m[MANT_W-1]) state_nxt = DIVIDE;
      DIVIDE:  if (cnt == '0) state_nxt = POST;
      POST:    state_nxt = NORM_2;
      NORM_2:  if (!(z_e < EXP_MIN)) state_nxt = ROUND;
      ROUND:   state_nxt = PACK;
      PACK:    state_nxt = PUT_Z;
      PUT_Z:   if (!i_request) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output control
  always_comb begin
    ready_nxt   = 1'b0;
    result_load = 1'b0;
    if (state == PUT_Z) begin
      ready_nxt   = i_request;
      result_load = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_ready  <= 1'b0;
      o_result <= '0;
    end else begin
      o_ready <= ready_nxt;
      if (result_load) o_result <= z;
    end
  end

  // Datapath
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      a_m       <= '0;
      b_m       <= '0;
      a_e       <= '0;
      b_e       <= '0;
      z_e       <= '0;
      z_m       <= '0;
      z_s       <= 1'b0;
      q         <= '0;
      rem       <= '0;
      cnt       <= '0;
      guard     <= 1'b0;
      round_bit <= 1'b0;
      sticky    <= 1'b0;
      z         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_request) begin
            a_m <= ua.mant;
            b_m <= ub.mant;
            a_e <= ua.exp;
            b_e <= ub.exp;
            z_s <= ua.sign ^ ub.sign;
          end
        end
        SPECIAL: begin
          if (special_hit) begin
            z <= special_z;
          end else begin
            // denormals keep hidden bit clear and take the minimum exponent
            if (a_e == EXP_DEN) a_e <= EXP_MIN;
            else                a_m[MANT_W-1] <= 1'b1;
            if (b_e == EXP_DEN) b_e <= EXP_MIN;
            else                b_m[MANT_W-1] <= 1'b1;
          end
        end
        NORM_A: begin
          if (!a_m[MANT_W-1]) begin
            a_m <= a_m << 1;
            a_e <= a_e - 10'sd1;
          end
        end
        NORM_B: begin
          if (!b_m[MANT_W-1]) begin
            b_m <= b_m << 1;
            b_e <= b_e - 10'sd1;
          end else begin
            rem <= {1'b0, a_m};
            q   <= '0;
            cnt <= CNT_W'(Q_W - 1);
            z_e <= a_e - b_e;
          end
        end
        DIVIDE: begin
          // one restoring step; both mantissas normalised so rem < 2*b_m
          if (rem >= {1'b0, b_m}) begin
            q   <= {q[Q_W-2:0], 1'b1};
            rem <= (rem - {1'b0, b_m}) << 1;
          end else begin
            q   <= {q[Q_W-2:0], 1'b0};
            rem <= rem << 1;
          end
          if (cnt != '0) cnt <= cnt - 5'd1;
        end
        POST: begin
          if (q[Q_W-1]) begin
            z_m       <= q[27:4];
            guard     <= q[3];
            round_bit <= q[2];
            sticky    <= q[1] | q[0] | (rem != '0);
          end else begin
            z_m       <= q[26:3];
            guard     <= q[2];
            round_bit <= q[1];
            sticky    <= q[0] | (rem != '0);
            z_e       <= z_e - 10'sd1;
          end
        end
        NORM_2: begin
          // denormalise one bit per cycle until the exponent is representable
          if (z_e < EXP_MIN) begin
            z_e       <= z_e + 10'sd1;
            z_m       <= z_m >> 1;
            guard     <= z_m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
          end
        end
        ROUND: begin
          z <= rp_result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fpu_div.sv
// Directed bench for cpu_fpu_div: stimulus pushes expected result and latency,
// a negedge monitor pops and checks on each rising o_ready.
module tb_cpu_fpu_div;

  logic        i_clock;
  logic        i_reset;
  logic        i_request;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        o_ready;
  logic [31:0] o_result;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
    int          cap;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_ready = 1'b0;

  cpu_fpu_div dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_request (i_request),
    .i_op1     (i_op1),
    .i_op2     (i_op2),
    .o_ready   (o_ready),
    .o_result  (o_result)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: compare each new result against the oldest outstanding request
  always @(negedge i_clock) begin
    if (o_ready && !prev_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got result %h with no request outstanding", o_result);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_result"}, o_result, mon_e.res);
        check({mon_e.name, "_latency"}, 32'(cyc - mon_e.cap), 32'(mon_e.lat));
      end
    end
    prev_ready = o_ready;
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input int hold);
    sb_t e;
    int  waited;
    @(negedge i_clock);
    i_op1     = a;
    i_op2     = b;
    i_request = 1'b1;
    @(posedge i_clock);
    #1;
    e.name = name;
    e.res  = res;
    e.lat  = lat;
    e.cap  = cyc;
    sb_q.push_back(e);
    waited = 0;
    while (!o_ready && waited < 300) begin
      @(negedge i_clock);
      waited++;
    end
    if (!o_ready) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: o_ready still 0 after %0d cycles, want 1", name, waited);
      void'(sb_q.pop_back());
      i_request = 1'b0;
      @(negedge i_clock);
      return;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge i_clock);
      check({name, "_hold_ready"}, 32'(o_ready), 32'd1);
      check({name, "_hold_result"}, o_result, res);
    end
    i_request = 1'b0;
    @(negedge i_clock);
    check({name, "_drop_ready"}, 32'(o_ready), 32'd0);
  endtask

  localparam int NV = 10;
  string       tv_name [NV];
  logic [31:0] tv_a    [NV];
  logic [31:0] tv_b    [NV];
  logic [31:0] tv_res  [NV];
  int          tv_lat  [NV];
  int          tv_hold [NV];

  initial begin
    tv_name[0] = "six_by_two";  tv_a[0] = 32'h40C00000; tv_b[0] = 32'h40000000; tv_res[0] = 32'h40400000; tv_lat[0] = 36; tv_hold[0] = 0;
    tv_name[1] = "one_third";   tv_a[1] = 32'h3F800000; tv_b[1] = 32'h40400000; tv_res[1] = 32'h3EAAAAAB; tv_lat[1] = 36; tv_hold[1] = 0;
    tv_name[2] = "pos_by_zero"; tv_a[2] = 32'h3F800000; tv_b[2] = 32'h00000000; tv_res[2] = 32'h7F800000; tv_lat[2] = 2;  tv_hold[2] = 0;
    tv_name[3] = "neg_by_zero"; tv_a[3] = 32'hBF800000; tv_b[3] = 32'h00000000; tv_res[3] = 32'hFF800000; tv_lat[3] = 2;  tv_hold[3] = 0;
    tv_name[4] = "zero_zero";   tv_a[4] = 32'h00000000; tv_b[4] = 32'h00000000; tv_res[4] = 32'hFFC00000; tv_lat[4] = 2;  tv_hold[4] = 0;
    tv_name[5] = "nan_in";      tv_a[5] = 32'h7FC00001; tv_b[5] = 32'h3F800000; tv_res[5] = 32'hFFC00000; tv_lat[5] = 2;  tv_hold[5] = 0;
    tv_name[6] = "overflow";    tv_a[6] = 32'h7F000000; tv_b[6] = 32'h00800000; tv_res[6] = 32'h7F800000; tv_lat[6] = 36; tv_hold[6] = 0;
    tv_name[7] = "to_denormal"; tv_a[7] = 32'h00800000; tv_b[7] = 32'h40000000; tv_res[7] = 32'h00400000; tv_lat[7] = 37; tv_hold[7] = 0;
    tv_name[8] = "min_denorm";  tv_a[8] = 32'h00000001; tv_b[8] = 32'h3F000000; tv_res[8] = 32'h00000002; tv_lat[8] = 81; tv_hold[8] = 0;
    tv_name[9] = "hold_six";    tv_a[9] = 32'h40C00000; tv_b[9] = 32'h40000000; tv_res[9] = 32'h40400000; tv_lat[9] = 36; tv_hold[9] = 5;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic saw_ready;
    i_reset   = 1'b1;
    i_request = 1'b0;
    i_op1     = '0;
    i_op2     = '0;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    check("reset_ready", 32'(o_ready), 32'd0);
    check("reset_result", o_result, 32'd0);
    i_reset = 1'b0;

    for (int i = 0; i < NV; i++)
      run_op(tv_name[i], tv_a[i], tv_b[i], tv_res[i], tv_lat[i], tv_hold[i]);

    // new operands straight after the held transaction: -10 / 5
    run_op("rereq_neg", 32'hC1200000, 32'h40A00000, 32'hC0000000, 36, 0);

    // reset during DIVIDE iteration 10 (edge 13 after capture)
    @(negedge i_clock);
    i_op1     = 32'h40C00000;
    i_op2     = 32'h40000000;
    i_request = 1'b1;
    @(posedge i_clock);
    #1;
    repeat (12) @(posedge i_clock);
    @(negedge i_clock);
    i_reset   = 1'b1;
    i_request = 1'b0;
    @(negedge i_clock);
    check("abort_ready", 32'(o_ready), 32'd0);
    i_reset = 1'b0;
    saw_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clock);
      if (o_ready) saw_ready = 1'b1;
    end
    check("abort_no_result", 32'(saw_ready), 32'd0);

    run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 36, 0);

    repeat (3) @(negedge i_clock);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
